// File: rtl/sys_cmd_pkg.sv
// Shared constants and types for the system command controller.
// Opcodes, FSM state encoding and operand register addresses.
package sys_cmd_pkg;

   localparam logic [7:0] OP_WR  = 8'hAA;
   localparam logic [7:0] OP_RD  = 8'hBB;
   localparam logic [7:0] OP_ALU = 8'hCC;
   localparam logic [7:0] OP_FN  = 8'hDD;
   localparam logic [7:0] OP_BRD = 8'hEE;

   localparam int RF_OPA = 0;
   localparam int RF_OPB = 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_RD_ADDR,
      S_BRD_ADDR,
      S_BRD_CNT,
      S_RD_REQ,
      S_RD_WAIT,
      S_RD_PUSH,
      S_OP_A,
      S_OP_B,
      S_FUNC,
      S_ALU_WAIT,
      S_TX_RES
   } state_t;

endpackage

// File: rtl/sys_cmd_if.sv
// Bus bundle of the command controller: RX bytes, TX FIFO,
// register file and ALU handshakes.
interface sys_cmd_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ALU_OUT_WIDTH = 16,
   parameter int ADDR_WIDTH    = 4
);
   logic [DATA_WIDTH-1:0]    rx_data;
   logic                     rx_valid;
   logic                     fifo_full;
   logic [DATA_WIDTH-1:0]    wr_data;
   logic                     wr_inc;
   logic                     wr_en;
   logic                     rd_en;
   logic [ADDR_WIDTH-1:0]    addr;
   logic [DATA_WIDTH-1:0]    wr_d;
   logic [DATA_WIDTH-1:0]    rd_data;
   logic                     rd_data_valid;
   logic                     alu_en;
   logic [3:0]               alu_func;
   logic [ALU_OUT_WIDTH-1:0] alu_out;
   logic                     alu_valid;
   logic                     gate_en;
   logic                     err;

   modport slave (
      input  rx_data, rx_valid, fifo_full,
      input  rd_data, rd_data_valid,
      input  alu_out, alu_valid,
      output wr_data, wr_inc, wr_en, rd_en,
      output addr, wr_d, alu_en, alu_func,
      output gate_en, err
   );

   modport master (
      output rx_data, rx_valid, fifo_full,
      output rd_data, rd_data_valid,
      output alu_out, alu_valid,
      input  wr_data, wr_inc, wr_en, rd_en,
      input  addr, wr_d, alu_en, alu_func,
      input  gate_en, err
   );

endinterface

// File: rtl/sys_cmd_ser.sv
// Result serializer: holds the ALU result and emits it LSB byte
// first, advancing only when a byte is actually pushed.
module sys_cmd_ser #(
   parameter int DATA_WIDTH    = 8,
   parameter int ALU_OUT_WIDTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_load,
   input  logic [ALU_OUT_WIDTH-1:0] i_din,
   input  logic                     i_en,
   input  logic                     i_full,
   output logic [DATA_WIDTH-1:0]    o_byte,
   output logic                     o_push,
   output logic                     o_last
);
   localparam int NB = ALU_OUT_WIDTH / DATA_WIDTH;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   logic [ALU_OUT_WIDTH-1:0] r_res;
   logic [IW-1:0]            r_idx;
   logic [ALU_OUT_WIDTH-1:0] w_sh;

   assign w_sh   = r_res >> (int'(r_idx) * DATA_WIDTH);
   assign o_byte = w_sh[DATA_WIDTH-1:0];
   assign o_push = i_en & ~i_full;
   assign o_last = (r_idx == IW'(NB - 1));

   // Capture result on load, step byte index on every push
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_res <= '0;
         r_idx <= '0;
      end else if (i_load) begin
         r_res <= i_din;
         r_idx <= '0;
      end else if (o_push) begin
         r_idx <= o_last ? '0 : r_idx + IW'(1);
      end
   end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Byte-command controller: RF write/read/burst-read and ALU ops.
// Optional inter-byte timeout enabled by macro SYS_CMD_TIMEOUT_EN.
module sys_cmd_ctrl
   import sys_cmd_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ALU_OUT_WIDTH  = 16,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   sys_cmd_if.slave   bus
);
   if (DATA_WIDTH < 8 || ALU_OUT_WIDTH % DATA_WIDTH != 0 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("sys_cmd_ctrl: bad parameters");
   end

   state_t                r_state;
   state_t                w_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_cnt;
   logic [DATA_WIDTH-1:0] r_hold;
   logic [DATA_WIDTH-1:0] w_byte;
   logic                  w_push;
   logic                  w_last;
   logic                  w_ser_en;
   logic                  w_load;
   logic                  w_tmo_hit;

   assign w_ser_en = (r_state == S_TX_RES);
   assign w_load   = (r_state == S_ALU_WAIT) & bus.alu_valid;

   sys_cmd_ser #(
      .DATA_WIDTH    (DATA_WIDTH),
      .ALU_OUT_WIDTH (ALU_OUT_WIDTH)
   ) u_ser (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (w_load),
      .i_din   (bus.alu_out),
      .i_en    (w_ser_en),
      .i_full  (bus.fifo_full),
      .o_byte  (w_byte),
      .o_push  (w_push),
      .o_last  (w_last)
   );

`ifdef SYS_CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo;
   logic          w_wait_st;

   assign w_wait_st = r_state inside {S_WR_ADDR, S_WR_DATA,
                                      S_RD_ADDR, S_BRD_ADDR,
                                      S_BRD_CNT, S_OP_A,
                                      S_OP_B, S_FUNC};
   assign w_tmo_hit = w_wait_st & ~bus.rx_valid &
                      (r_tmo == TW'(TIMEOUT_CYCLES - 1));

   // Silence counter, restarted on state entry and on each byte
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_tmo <= '0;
      else if (!w_wait_st || bus.rx_valid || w_nxt != r_state)
         r_tmo <= '0;
      else
         r_tmo <= r_tmo + TW'(1);
   end
`else
   assign w_tmo_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_nxt;
   end

   // Address, read count and read-hold registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr <= '0;
         r_cnt  <= '0;
         r_hold <= '0;
      end else begin
         unique case (r_state)
            S_WR_ADDR, S_BRD_ADDR: begin
               if (bus.rx_valid)
                  r_addr <= bus.rx_data[ADDR_WIDTH-1:0];
            end
            S_RD_ADDR: begin
               if (bus.rx_valid) begin
                  r_addr <= bus.rx_data[ADDR_WIDTH-1:0];
                  r_cnt  <= DATA_WIDTH'(1);
               end
            end
            S_BRD_CNT: begin
               if (bus.rx_valid) r_cnt <= bus.rx_data;
            end
            S_RD_WAIT: begin
               if (bus.rd_data_valid) r_hold <= bus.rd_data;
            end
            S_RD_PUSH: begin
               if (!bus.fifo_full) begin
                  r_cnt  <= r_cnt - DATA_WIDTH'(1);
                  r_addr <= r_addr + ADDR_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Next state and Mealy strobes
   always_comb begin
      w_nxt        = r_state;
      bus.wr_en    = 1'b0;
      bus.rd_en    = 1'b0;
      bus.addr     = '0;
      bus.wr_d     = '0;
      bus.alu_en   = 1'b0;
      bus.alu_func = '0;
      bus.wr_inc   = 1'b0;
      bus.wr_data  = '0;
      bus.gate_en  = 1'b0;
      bus.err      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.rx_valid) begin
               unique case (1'b1)
                  bus.rx_data == DATA_WIDTH'(OP_WR):  w_nxt = S_WR_ADDR;
                  bus.rx_data == DATA_WIDTH'(OP_RD):  w_nxt = S_RD_ADDR;
                  bus.rx_data == DATA_WIDTH'(OP_BRD): w_nxt = S_BRD_ADDR;
                  bus.rx_data == DATA_WIDTH'(OP_ALU): w_nxt = S_OP_A;
                  bus.rx_data == DATA_WIDTH'(OP_FN):  w_nxt = S_FUNC;
                  default:                            bus.err = 1'b1;
               endcase
            end
         end
         S_WR_ADDR:  if (bus.rx_valid) w_nxt = S_WR_DATA;
         S_WR_DATA: begin
            if (bus.rx_valid) begin
               bus.wr_en = 1'b1;
               bus.addr  = r_addr;
               bus.wr_d  = bus.rx_data;
               w_nxt     = S_IDLE;
            end
         end
         S_RD_ADDR:  if (bus.rx_valid) w_nxt = S_RD_REQ;
         S_BRD_ADDR: if (bus.rx_valid) w_nxt = S_BRD_CNT;
         S_BRD_CNT: begin
            if (bus.rx_valid)
               w_nxt = (bus.rx_data == '0) ? S_IDLE : S_RD_REQ;
         end
         S_RD_REQ: begin
            bus.rd_en = 1'b1;
            bus.addr  = r_addr;
            w_nxt     = S_RD_WAIT;
         end
         S_RD_WAIT: if (bus.rd_data_valid) w_nxt = S_RD_PUSH;
         S_RD_PUSH: begin
            if (!bus.fifo_full) begin
               bus.wr_inc  = 1'b1;
               bus.wr_data = r_hold;
               w_nxt = (r_cnt == DATA_WIDTH'(1)) ? S_IDLE : S_RD_REQ;
            end
         end
         S_OP_A: begin
            if (bus.rx_valid) begin
               bus.wr_en = 1'b1;
               bus.addr  = ADDR_WIDTH'(RF_OPA);
               bus.wr_d  = bus.rx_data;
               w_nxt     = S_OP_B;
            end
         end
         S_OP_B: begin
            if (bus.rx_valid) begin
               bus.wr_en = 1'b1;
               bus.addr  = ADDR_WIDTH'(RF_OPB);
               bus.wr_d  = bus.rx_data;
               w_nxt     = S_FUNC;
            end
         end
         S_FUNC: begin
            bus.gate_en = 1'b1;
            if (bus.rx_valid) begin
               bus.alu_en   = 1'b1;
               bus.alu_func = bus.rx_data[3:0];
               w_nxt        = S_ALU_WAIT;
            end
         end
         S_ALU_WAIT: begin
            bus.gate_en = 1'b1;
            if (bus.alu_valid) w_nxt = S_TX_RES;
         end
         S_TX_RES: begin
            bus.wr_inc  = w_push;
            bus.wr_data = w_byte;
            if (w_push && w_last) w_nxt = S_IDLE;
         end
         default: w_nxt = S_IDLE;
      endcase
      if (w_tmo_hit) begin
         w_nxt   = S_IDLE;
         bus.err = 1'b1;
      end
   end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Scoreboard bench for sys_cmd_ctrl with RF and ALU responders.
// Timeout scenario runs when SYS_CMD_TIMEOUT_EN is defined.
module tb_sys_cmd_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   sys_cmd_if #(
      .DATA_WIDTH(8), .ALU_OUT_WIDTH(16), .ADDR_WIDTH(4)
   ) bus ();

   sys_cmd_ctrl #(
      .DATA_WIDTH(8), .ALU_OUT_WIDTH(16),
      .ADDR_WIDTH(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_err   = 0;

   logic [11:0] q_wr[$];
   logic [3:0]  q_rd[$];
   logic [7:0]  q_push[$];
   logic [3:0]  q_fn[$];

   logic [7:0]  rf[16];
   logic [15:0] alu_val;
   int          rd_pend = 0;
   int          alu_pend = 0;
   logic [3:0]  rd_a;

   // RF and ALU responders (fixed latencies)
   always @(negedge clk) begin
      bus.rd_data_valid = 1'b0;
      bus.alu_valid     = 1'b0;
      if (rd_pend > 0) begin
         rd_pend--;
         if (rd_pend == 0) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data       = rf[rd_a];
         end
      end
      if (alu_pend > 0) begin
         alu_pend--;
         if (alu_pend == 0) begin
            bus.alu_valid = 1'b1;
            bus.alu_out   = alu_val;
         end
      end
      if (rst_n && bus.rd_en === 1'b1) begin
         rd_pend = 2;
         rd_a    = bus.addr;
      end
      if (rst_n && bus.alu_en === 1'b1) alu_pend = 3;
   end

   // Scoreboard monitor on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.err === 1'b1) n_err++;
         if (bus.wr_en !== 1'b0) begin
            n_tests++;
            if (q_wr.size() == 0) begin
               n_fail++;
               $display("FAIL rf_write unexpected got=%h_%h",
                        bus.addr, bus.wr_d);
            end else begin
               logic [11:0] e;
               e = q_wr.pop_front();
               if ({bus.addr, bus.wr_d} !== e) begin
                  n_fail++;
                  $display("FAIL rf_write got=%h_%h exp=%h_%h",
                           bus.addr, bus.wr_d, e[11:8], e[7:0]);
               end
            end
         end
         if (bus.rd_en !== 1'b0) begin
            n_tests++;
            if (q_rd.size() == 0) begin
               n_fail++;
               $display("FAIL rf_read unexpected addr=%h", bus.addr);
            end else begin
               logic [3:0] e;
               e = q_rd.pop_front();
               if (bus.addr !== e) begin
                  n_fail++;
                  $display("FAIL rf_read got=%h exp=%h", bus.addr, e);
               end
            end
         end
         if (bus.wr_inc !== 1'b0) begin
            n_tests++;
            if (q_push.size() == 0) begin
               n_fail++;
               $display("FAIL push unexpected data=%h", bus.wr_data);
            end else begin
               logic [7:0] e;
               e = q_push.pop_front();
               if (bus.wr_data !== e) begin
                  n_fail++;
                  $display("FAIL push got=%h exp=%h", bus.wr_data, e);
               end
            end
         end
         if (bus.alu_en !== 1'b0) begin
            n_tests++;
            if (q_fn.size() == 0) begin
               n_fail++;
               $display("FAIL alu_start unexpected fn=%h", bus.alu_func);
            end else begin
               logic [3:0] e;
               e = q_fn.pop_front();
               if (bus.alu_func !== e) begin
                  n_fail++;
                  $display("FAIL alu_func got=%h exp=%h", bus.alu_func, e);
               end
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
   endtask

   task automatic drain(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (q_wr.size() == 0 && q_rd.size() == 0 &&
             q_push.size() == 0 && q_fn.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   function automatic int pending();
      return q_wr.size() + q_rd.size() + q_push.size() + q_fn.size();
   endfunction

   task automatic test_reset();
      logic [28:0] o;
      bus.rx_valid  = 1'b0;
      bus.rx_data   = '0;
      bus.fifo_full = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      o = {bus.wr_en, bus.rd_en, bus.addr, bus.wr_d, bus.alu_en,
           bus.alu_func, bus.wr_inc, bus.wr_data, bus.gate_en,
           bus.err};
      n_tests++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h exp=0", o);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      bit ok;
      int e0;
      e0 = n_err;
      q_wr.push_back({4'h5, 8'h3C});
      send(8'hAA); send(8'h05); send(8'h3C);
      drain(10, ok);
      n_tests++;
      if (!ok || n_err != e0) begin
         n_fail++;
         $display("FAIL write pending=%0d errs=%0d exp=0",
                  pending(), n_err - e0);
      end
   endtask

   task automatic test_burst_wrap();
      bit ok;
      rf[14] = 8'h11; rf[15] = 8'h22; rf[0] = 8'h33;
      q_rd.push_back(4'hE); q_rd.push_back(4'hF); q_rd.push_back(4'h0);
      q_push.push_back(8'h11); q_push.push_back(8'h22);
      q_push.push_back(8'h33);
      send(8'hEE); send(8'h0E); send(8'h03);
      drain(60, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL burst_wrap pending=%0d exp=0", pending());
      end
   endtask

   task automatic test_alu();
      bit ok;
      bit got;
      alu_val = 16'hBEEF;
      q_wr.push_back({4'h0, 8'h07});
      q_wr.push_back({4'h1, 8'h09});
      q_fn.push_back(4'h2);
      q_push.push_back(8'hEF); q_push.push_back(8'hBE);
      send(8'hCC); send(8'h07); send(8'h09);
      @(negedge clk);
      n_tests++;
      if (bus.gate_en !== 1'b1) begin
         n_fail++;
         $display("FAIL gate_func got=%b exp=1", bus.gate_en);
      end
      @(posedge clk); #1;
      bus.fifo_full = 1'b1;
      send(8'h02);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         if (bus.alu_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL alu_valid_wait got=0 exp=1");
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if (bus.gate_en !== 1'b0 || bus.wr_inc !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_hold gate=%b push=%b exp=0,0",
                     bus.gate_en, bus.wr_inc);
         end
      end
      @(posedge clk); #1;
      bus.fifo_full = 1'b0;
      drain(20, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL alu_tx pending=%0d exp=0", pending());
      end
   endtask

   task automatic test_zero_cnt_and_err();
      bit ok;
      int e0;
      send(8'hEE); send(8'h04); send(8'h00);
      repeat (4) @(posedge clk);
      #1;
      e0 = n_err;
      send(8'h55);
      n_tests++;
      if (n_err != e0 + 1) begin
         n_fail++;
         $display("FAIL bad_opcode_err got=%0d exp=1", n_err - e0);
      end
      e0 = n_err;
      q_wr.push_back({4'h3, 8'h44});
      send(8'hAA); send(8'h03); send(8'h44);
      drain(10, ok);
      n_tests++;
      if (!ok || n_err != e0) begin
         n_fail++;
         $display("FAIL idle_after_err pending=%0d errs=%0d exp=0",
                  pending(), n_err - e0);
      end
   endtask

`ifdef SYS_CMD_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int cyc;
      cyc = 0;
      send(8'hAA);
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.err === 1'b1) begin
            cyc = i;
            break;
         end
      end
      n_tests++;
      if (cyc != 16) begin
         n_fail++;
         $display("FAIL timeout_cycle got=%0d exp=16", cyc);
      end
      @(posedge clk); #1;
      q_wr.push_back({4'h2, 8'h55});
      send(8'hAA); send(8'h02); send(8'h55);
      drain(10, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL after_timeout pending=%0d exp=0", pending());
      end
   endtask
`endif

   task automatic test_reset_mid();
      bit ok;
      logic [28:0] o;
      rf[3] = 8'h77;
      rf[2] = 8'h5A;
      q_rd.push_back(4'h3);
      send(8'hBB); send(8'h03);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      o = {bus.wr_en, bus.rd_en, bus.addr, bus.wr_d, bus.alu_en,
           bus.alu_func, bus.wr_inc, bus.wr_data, bus.gate_en,
           bus.err};
      n_tests++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs got=%h exp=0", o);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (q_rd.size() != 0) begin
         n_fail++;
         $display("FAIL reset_mid_rd got=%0d exp=0", q_rd.size());
      end
      q_rd.delete();
      q_rd.push_back(4'h2);
      q_push.push_back(8'h5A);
      send(8'hBB); send(8'h02);
      drain(20, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL read_after_reset pending=%0d exp=0", pending());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_burst_wrap();
      test_alu();
      test_zero_cnt_and_err();
`ifdef SYS_CMD_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
